// File: rtl/input_module.sv
// Front-panel key handler: per-key synchronizer and debounce, mode/field selection,
// and one-cycle inc/dec strobes with hold-to-repeat for the selected field.
//
//   state   | meaning
//   M_CLOCK | clock view/set, 3 editable fields (sec/min/hour)
//   M_DATE  | date view/set, 5 editable fields
//   M_DDAY  | D-day display only, no editable fields
//   M_DSET  | D-day set, 5 editable fields, set_dday asserted

module input_module #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_field,
  input  logic        key_up,
  input  logic        key_down,
  output logic [2:0]  mode,
  output logic [12:0] select,
  output logic        set_dday,
  output logic        inc_pulse,
  output logic        dec_pulse
);

  typedef enum logic [1:0] {
    M_CLOCK = 2'd0,
    M_DATE  = 2'd1,
    M_DDAY  = 2'd2,
    M_DSET  = 2'd3
  } mode_t;

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RP_W   = $clog2(RP_MAX + 1);
  localparam logic [DB_W-1:0] DB_TC  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RP_W-1:0] HOLD_LD = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] REP_LD  = RP_W'(REPEAT_CYCLES - 1);

  // Key order in all 4-bit vectors: 0 mode, 1 field, 2 up, 3 down.
  logic [3:0]      key_raw;
  logic [3:0]      sync1, sync2, key_acc, key_evt;
  logic [DB_W-1:0] db_cnt [4];

  assign key_raw = {key_down, key_up, key_field, key_mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Accepted level flips once the counter has seen DEBOUNCE_CYCLES differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      key_acc <= '1;
      key_evt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        key_evt[i] <= 1'b0;
        if (sync2[i] == key_acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_TC) begin
          db_cnt[i]  <= '0;
          key_acc[i] <= sync2[i];
          key_evt[i] <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic mode_evt, field_evt, up_evt, dn_evt;
  assign mode_evt  = key_evt[0];
  assign field_evt = key_evt[1];
  assign up_evt    = key_evt[2];
  assign dn_evt    = key_evt[3];

  mode_t           mode_q, mode_nxt;
  logic [2:0]      fld, fld_nxt, n_fld;
  logic            rep_on, rep_dn;
  logic [RP_W-1:0] rep_cnt;
  logic            pulse_busy, single_press, press_ok, up_held, dn_held, holding;

  always_comb begin
    case (mode_q)
      M_CLOCK: n_fld = 3'd3;
      M_DDAY:  n_fld = 3'd0;
      default: n_fld = 3'd5;
    endcase
  end

  always_comb begin
    mode_nxt = mode_q;
    fld_nxt  = fld;
    if (mode_evt) begin
      mode_nxt = mode_t'(mode_q + 2'd1);
      fld_nxt  = 3'd0;
    end else if (field_evt && (n_fld != 3'd0)) begin
      fld_nxt = (fld == n_fld) ? 3'd0 : fld + 3'd1;
    end
  end

  function automatic logic [12:0] decode_sel(input mode_t m, input logic [2:0] f);
    logic [3:0] idx;
    idx        = 4'(f);
    decode_sel = '0;
    if (f != 3'd0) begin
      case (m)
        M_CLOCK: decode_sel = 13'd1 << (idx - 4'd1);
        M_DATE:  decode_sel = 13'd1 << (idx + 4'd2);
        M_DSET:  decode_sel = 13'd1 << (idx + 4'd7);
        default: decode_sel = '0;
      endcase
    end
  endfunction

  // pulse_busy keeps strobes from ever being high on back-to-back cycles.
  assign pulse_busy   = inc_pulse | dec_pulse;
  assign single_press = up_evt ^ dn_evt;
  assign press_ok     = single_press && !mode_evt && (fld != 3'd0);
  assign up_held      = !key_acc[2] && key_acc[3];
  assign dn_held      = !key_acc[3] && key_acc[2];
  assign holding      = rep_on && (rep_dn ? dn_held : up_held) &&
                        !mode_evt && !field_evt && (fld != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= M_CLOCK;
      fld       <= 3'd0;
      select    <= '0;
      set_dday  <= 1'b0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      rep_on    <= 1'b0;
      rep_dn    <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      mode_q    <= mode_nxt;
      fld       <= fld_nxt;
      select    <= decode_sel(mode_nxt, fld_nxt);
      set_dday  <= (mode_nxt == M_DSET);
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      if (press_ok) begin
        inc_pulse <= up_evt && !pulse_busy;
        dec_pulse <= dn_evt && !pulse_busy;
        rep_on    <= !field_evt && (up_evt ? up_held : dn_held);
        rep_dn    <= dn_evt;
        rep_cnt   <= HOLD_LD;
      end else if (holding) begin
        if (rep_cnt == '0) begin
          rep_cnt   <= REP_LD;
          inc_pulse <= !rep_dn && !pulse_busy;
          dec_pulse <= rep_dn && !pulse_busy;
        end else begin
          rep_cnt <= rep_cnt - 1'b1;
        end
      end else begin
        rep_on  <= 1'b0;
        rep_cnt <= '0;
      end
    end
  end

  assign mode = {1'b0, mode_q};

endmodule

// File: tb/tb_input_module.sv
// Scoreboard bench for input_module: every output change or strobe is an event that
// must match the next expected event pushed when the key stimulus was driven.

module tb_input_module;

  localparam int D   = 4;
  localparam int H   = 10;
  localparam int R   = 3;
  localparam int LAT = 3 + D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  keys = 4'hF;
  logic [2:0]  mode;
  logic [12:0] select;
  logic        set_dday, inc_pulse, dec_pulse;

  input_module #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_mode(keys[0]),
    .key_field(keys[1]),
    .key_up(keys[2]),
    .key_down(keys[3]),
    .mode(mode),
    .select(select),
    .set_dday(set_dday),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int md;
    int sel;
    int sdd;
    int inc;
    int dec;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_mode = 0;
  int   m_fld = 0;
  bit   mon_en = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int sel_model(input int md, input int f);
    int base;
    if (f == 0 || md == 2) return 0;
    base = (md == 0) ? 0 : (md == 1) ? 3 : 8;
    return 1 << (base + f - 1);
  endfunction

  function automatic int nfld_model(input int md);
    return (md == 0) ? 3 : (md == 2) ? 0 : 5;
  endfunction

  task automatic push_evt(input int at, input int inc, input int dec);
    exp_t e;
    e.cyc = at;
    e.md  = m_mode;
    e.sel = sel_model(m_mode, m_fld);
    e.sdd = (m_mode == 3) ? 1 : 0;
    e.inc = inc;
    e.dec = dec;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one key low for 'hold' cycles and push everything it should cause.
  task automatic press(input int idx, input int hold);
    int t, lim, n;
    t = cyc + 1;
    keys[idx] = 1'b0;
    case (idx)
      0: begin
        m_mode = (m_mode + 1) % 4;
        m_fld  = 0;
        push_evt(t + LAT, 0, 0);
      end
      1: begin
        n = nfld_model(m_mode);
        if (n != 0) begin
          m_fld = (m_fld + 1) % (n + 1);
          push_evt(t + LAT, 0, 0);
        end
      end
      default: begin
        if (m_fld != 0) begin
          push_evt(t + LAT, (idx == 2) ? 1 : 0, (idx == 3) ? 1 : 0);
          lim = t + hold + 2 + D;
          for (int e = t + LAT + H; e <= lim; e += R)
            push_evt(e, (idx == 2) ? 1 : 0, (idx == 3) ? 1 : 0);
        end
      end
    endcase
    tick(hold);
    keys[idx] = 1'b1;
    tick(12);
  endtask

  int   prev_md, prev_sel, prev_sdd;
  exp_t got;

  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        got = exp_q.pop_front();
        check_val("missed_event", -1, got.cyc);
      end
      if (inc_pulse || dec_pulse || int'(mode) != prev_md ||
          int'(select) != prev_sel || int'(set_dday) != prev_sdd) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_event_cycle", cyc, -1);
        end else begin
          got = exp_q.pop_front();
          check_val("event_cycle", cyc, got.cyc);
          check_val("mode", int'(mode), got.md);
          check_val("select", int'(select), got.sel);
          check_val("set_dday", int'(set_dday), got.sdd);
          check_val("inc_pulse", int'(inc_pulse), got.inc);
          check_val("dec_pulse", int'(dec_pulse), got.dec);
        end
      end
    end
    prev_md  = int'(mode);
    prev_sel = int'(select);
    prev_sdd = int'(set_dday);
  end

  initial begin
    int t;
    tick(3);
    check_val("rst_mode", int'(mode), 0);
    check_val("rst_select", int'(select), 0);
    check_val("rst_set_dday", int'(set_dday), 0);
    check_val("rst_inc", int'(inc_pulse), 0);
    check_val("rst_dec", int'(dec_pulse), 0);
    rst = 1'b0;
    tick(2);
    mon_en = 1'b1;

    // Mode walk 1,2,3,0,1.
    for (int i = 0; i < 5; i++) press(0, 8);

    // Mode 1 field cycling, then mode 0, then mode 2.
    for (int i = 0; i < 6; i++) press(1, 8);
    for (int i = 0; i < 3; i++) press(0, 8);
    for (int i = 0; i < 4; i++) press(1, 8);
    press(0, 8);
    press(0, 8);
    press(1, 8);
    press(1, 8);
    check_val("mode2_select", int'(select), 0);

    // Mode 0, fld=2: held down auto-repeats; then same hold with fld=0.
    press(0, 8);
    press(0, 8);
    press(1, 8);
    press(1, 8);
    check_val("fld2_select", int'(select), 'h002);
    press(3, 30);
    press(1, 8);
    press(1, 8);
    press(3, 30);

    // Bouncy up key on fld=1, then a clean hold.
    press(1, 8);
    for (int i = 0; i < 3; i++) begin
      keys[2] = 1'b0;
      tick(3);
      keys[2] = 1'b1;
      tick(2);
    end
    press(2, 8);

    // Mode and field in the same cycle from mode 1, select 0x010.
    press(0, 8);
    press(1, 8);
    press(1, 8);
    check_val("pre_simul_select", int'(select), 'h010);
    t = cyc + 1;
    keys[0] = 1'b0;
    keys[1] = 1'b0;
    m_mode = 2;
    m_fld  = 0;
    push_evt(t + LAT, 0, 0);
    tick(8);
    keys[1:0] = 2'b11;
    tick(12);

    // Mode 3, fld=1: up and down together give nothing.
    press(0, 8);
    press(1, 8);
    keys[3:2] = 2'b00;
    tick(20);
    keys[3:2] = 2'b11;
    tick(12);

    // Mode 3, select 0x400, repeating up key interrupted by reset.
    press(1, 8);
    press(1, 8);
    check_val("pre_rst_select", int'(select), 'h400);
    t = cyc + 1;
    keys[2] = 1'b0;
    push_evt(t + LAT, 1, 0);
    push_evt(t + LAT + H, 1, 0);
    tick(LAT + H + 1 + 1);
    rst = 1'b1;
    m_mode = 0;
    m_fld  = 0;
    push_evt(t + LAT + H + 2, 0, 0);
    tick(1);
    rst = 1'b0;
    tick(30);
    keys[2] = 1'b1;
    tick(15);
    check_val("post_rst_mode", int'(mode), 0);
    check_val("post_rst_select", int'(select), 0);

    check_val("pending_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
